// File: rtl/uart_tx_scheduler_if.sv
// Signal bundle between the byte producers / UART TX core and the scheduler.
// Handshakes: inN_valid is a fire-and-forget strobe, one byte per high cycle, never back-pressured.
// tx_start is a one-cycle request and tx_busy is the acknowledge, held high while the frame shifts.
interface uart_tx_scheduler_if;
    logic [7:0] in0_data;
    logic       in0_valid;
    logic [7:0] in1_data;
    logic       in1_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [1:0] ch_full;
    logic [1:0] ovf;
    logic       ack_err;
    logic       sched_busy;

    modport slave (
        input  in0_data, in0_valid, in1_data, in1_valid, tx_busy,
        output tx_data, tx_start, ch_full, ovf, ack_err, sched_busy
    );

    modport master (
        output in0_data, in0_valid, in1_data, in1_valid, tx_busy,
        input  tx_data, tx_start, ch_full, ovf, ack_err, sched_busy
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Two-channel byte FIFOs feeding one UART transmitter through a round-robin scheduler
// with a start/busy handshake and an acknowledge timeout.
module uart_tx_scheduler #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_scheduler_if.slave  bus,
    output logic [1:0]          dbg_state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(ACK_TIMEOUT);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] TMR_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [2][DEPTH];
    logic [AW-1:0]   wp_q  [2];
    logic [AW-1:0]   rp_q  [2];
    logic [AW:0]     cnt_q [2];
    logic [AW:0]     cnt_d [2];
    logic [7:0]      in_data [2];
    logic [1:0]      in_valid;
    logic [1:0]      full, nempty, wr, drop, pop;
    logic [1:0]      ovf_q;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            ack_err_q, ack_err_d;
    logic            last_q, last_d;
    logic            gch;
    logic [CW-1:0]   tmr_q, tmr_d;

    assign in_data[0] = bus.in0_data;
    assign in_data[1] = bus.in1_data;
    assign in_valid   = {bus.in1_valid, bus.in0_valid};

    // Fullness uses the registered count, so a same-cycle pop never makes room for a write.
    for (genvar g = 0; g < 2; g++) begin : g_ch
        assign full[g]   = (cnt_q[g] == FULL_CNT);
        assign nempty[g] = (cnt_q[g] != '0);
        assign wr[g]     = in_valid[g] && !full[g];
        assign drop[g]   = in_valid[g] && full[g];
        assign cnt_d[g]  = cnt_q[g] + (AW+1)'(wr[g]) - (AW+1)'(pop[g]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                wp_q[ch]  <= '0;
                rp_q[ch]  <= '0;
                cnt_q[ch] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (wr[ch]) begin
                    mem_q[ch][wp_q[ch]] <= in_data[ch];
                    wp_q[ch]            <= wp_q[ch] + AW'(1);
                end
                if (pop[ch]) begin
                    rp_q[ch] <= rp_q[ch] + AW'(1);
                end
                cnt_q[ch] <= cnt_d[ch];
                if (drop[ch]) begin
                    ovf_q[ch] <= 1'b1;
                end
            end
        end
    end

    // On a tie the channel that did not win last time is granted.
    assign gch = (nempty[0] && nempty[1]) ? ~last_q : nempty[1];

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        ack_err_d  = ack_err_q;
        last_d     = last_q;
        tmr_d      = tmr_q;
        pop        = '0;
        case (state_q)
            IDLE: begin
                if (nempty != 2'b00) begin
                    pop[gch]   = 1'b1;
                    tx_data_d  = mem_q[gch][rp_q[gch]];
                    tx_start_d = 1'b1;
                    last_d     = gch;
                    tmr_d      = '0;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q == TMR_LAST) begin
                    ack_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmr_d = tmr_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            ack_err_q  <= 1'b0;
            last_q     <= 1'b1;
            tmr_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            ack_err_q  <= ack_err_d;
            last_q     <= last_d;
            tmr_q      <= tmr_d;
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.ch_full    = full;
    assign bus.ovf        = ovf_q;
    assign bus.ack_err    = ack_err_q;
    assign bus.sched_busy = (state_q != IDLE);
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: scenario tasks, a UART TX behavioural model driving tx_busy,
// and a round-robin queue model that predicts transmit order.
module tb_uart_tx_scheduler;
    localparam int DEPTH       = 4;
    localparam int ACK_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    uart_tx_scheduler_if bus();

    uart_tx_scheduler #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bit tx_ack_en = 1'b1;
    bit tx_hold   = 1'b0;
    int tx_delay  = 1;
    int tx_len    = 3;
    int pend      = 0;
    int rem       = 0;
    bit prev_start = 1'b0;

    logic [7:0] obs_q [$];
    int         obs_cyc [$];
    logic [7:0] exp_q [$];
    logic [7:0] m0_q [$];
    logic [7:0] m1_q [$];
    bit         m_last;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // TX core model: raises busy tx_delay cycles after start, holds it tx_len cycles (or while tx_hold).
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.tx_busy = 1'b0;
                pend = 0;
                rem  = 0;
            end else begin
                if (bus.tx_busy && !tx_hold) begin
                    if (rem <= 1) bus.tx_busy = 1'b0;
                    else rem--;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.tx_busy = 1'b1;
                        rem = tx_len;
                    end
                end
                if (bus.tx_start && tx_ack_en) pend = tx_delay;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus.tx_start) begin
            checks++;
            if (prev_start) begin
                errors++;
                $display("FAIL start_pulse_width: tx_start high in consecutive cycles at cycle %0d, required one-cycle pulse", cyc);
            end
            obs_q.push_back(bus.tx_data);
            obs_cyc.push_back(cyc);
        end
        prev_start = bus.tx_start;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.in0_data  = 8'h00;
        bus.in1_data  = 8'h00;
        tx_hold   = 1'b0;
        tx_ack_en = 1'b1;
        tx_delay  = 1;
        tx_len    = 3;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
        m0_q.delete();
        m1_q.delete();
    endtask

    task automatic wr(input int ch, input logic [7:0] b);
        if (ch == 0) begin bus.in0_valid = 1'b1; bus.in0_data = b; end
        else         begin bus.in1_valid = 1'b1; bus.in1_data = b; end
        tick(1);
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
    endtask

    task automatic wr2(input logic [7:0] b0, input logic [7:0] b1);
        bus.in0_valid = 1'b1; bus.in0_data = b0;
        bus.in1_valid = 1'b1; bus.in1_data = b1;
        tick(1);
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, input string tag);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (obs_q.size() < n) begin
            errors++;
            $display("FAIL %s_wait: saw %0d tx_start pulses, required %0d", tag, obs_q.size(), n);
        end
    endtask

    // Round-robin reference: drain both model queues, alternating on ties.
    task automatic model_drain();
        bit pick;
        while (m0_q.size() > 0 || m1_q.size() > 0) begin
            if (m0_q.size() > 0 && m1_q.size() > 0) pick = ~m_last;
            else pick = (m1_q.size() > 0);
            if (pick) exp_q.push_back(m1_q.pop_front());
            else      exp_q.push_back(m0_q.pop_front());
            m_last = pick;
        end
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        checks++;
        if ({bus.tx_data, bus.tx_start, bus.ch_full, bus.ovf, bus.ack_err, bus.sched_busy} !== 15'd0) begin
            errors++;
            $display("FAIL reset_initial: outputs %h, required 0", {bus.tx_data, bus.tx_start, bus.ch_full, bus.ovf, bus.ack_err, bus.sched_busy});
        end
        tx_ack_en = 1'b0;
        wr(1, 8'h55);
        tick(ACK_TIMEOUT + 4);
        tx_ack_en = 1'b1;
        tx_hold   = 1'b1;
        wr(0, 8'h99);
        for (int i = 0; i < 6; i++) wr(1, 8'h60 + 8'(i));
        n = 0;
        while (dbg_state != 2'd2 && n < 20) begin tick(1); n++; end
        checks++;
        if (dbg_state != 2'd2 || bus.ack_err !== 1'b1 || bus.ovf !== 2'b10) begin
            errors++;
            $display("FAIL reset_setup: state %0d ack_err %b ovf %b, required 2 1 10", dbg_state, bus.ack_err, bus.ovf);
        end
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++;
        if (bus.tx_data !== 8'h00 || bus.tx_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx: tx_data %h tx_start %b, required 00 0", bus.tx_data, bus.tx_start);
        end
        checks++;
        if (bus.ovf !== 2'b00 || bus.ack_err !== 1'b0 || bus.ch_full !== 2'b00 || bus.sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ovf %b ack_err %b ch_full %b sched_busy %b, required 00 0 00 0",
                     bus.ovf, bus.ack_err, bus.ch_full, bus.sched_busy);
        end
        tx_hold = 1'b0;
        n = obs_q.size();
        tick(30);
        checks++;
        if (obs_q.size() != n) begin
            errors++;
            $display("FAIL reset_flush: %0d bytes sent after reset, required 0", obs_q.size() - n);
        end
        wr2(8'hC0, 8'hC1);
        wait_obs(n + 2, 60, "reset_tie");
        checks++;
        if (obs_q.size() >= n + 2 && (obs_q[n] !== 8'hC0 || obs_q[n+1] !== 8'hC1)) begin
            errors++;
            $display("FAIL reset_last_grant: order %h %h, required c0 c1", obs_q[n], obs_q[n+1]);
        end
    endtask

    task automatic test_single();
        do_reset();
        tx_delay = 1;
        tx_len   = 10;
        wr(0, 8'hA5);
        checks++;
        if (bus.tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_early: tx_start %b at t+1, required 0", bus.tx_start);
        end
        tick(1);
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_latency: tx_start %b tx_data %h at t+2, required 1 a5", bus.tx_start, bus.tx_data);
        end
        for (int c = 0; c < 14; c++) begin
            checks++;
            if (bus.sched_busy !== (c <= tx_delay + tx_len)) begin
                errors++;
                $display("FAIL single_sched_busy: %b at start+%0d, required %b", bus.sched_busy, c, (c <= tx_delay + tx_len));
            end
            tick(1);
        end
        checks++;
        if (bus.tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold: tx_data %h after frame, required a5", bus.tx_data);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        wr2(8'h01, 8'h11);
        wr2(8'h02, 8'h12);
        m0_q = '{8'h01, 8'h02};
        m1_q = '{8'h11, 8'h12};
        m_last = 1'b1;
        model_drain();
        wait_obs(exp_q.size(), 200, "rr");
        tick(10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rr_count: %0d bytes, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b [6];
        do_reset();
        tx_hold = 1'b1;
        for (int i = 0; i < 6; i++) b[i] = 8'h20 + 8'(i);
        for (int i = 0; i < 6; i++) begin
            wr(1, b[i]);
            if (i == 4) begin
                checks++;
                if (bus.ch_full !== 2'b10 || bus.ovf !== 2'b00) begin
                    errors++;
                    $display("FAIL ovf_full: ch_full %b ovf %b, required 10 00", bus.ch_full, bus.ovf);
                end
            end
        end
        checks++;
        if (bus.ovf !== 2'b10 || bus.ch_full !== 2'b10) begin
            errors++;
            $display("FAIL ovf_drop: ovf %b ch_full %b, required 10 10", bus.ovf, bus.ch_full);
        end
        tx_hold = 1'b0;
        for (int i = 0; i <= DEPTH; i++) exp_q.push_back(b[i]);
        wait_obs(exp_q.size(), 200, "ovf");
        tick(10);
        checks++;
        if (obs_q.size() != exp_q.size() || bus.ovf !== 2'b10 || bus.ch_full !== 2'b00) begin
            errors++;
            $display("FAIL ovf_drain: %0d bytes ovf %b ch_full %b, required %0d 10 00", obs_q.size(), bus.ovf, bus.ch_full, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_order[%0d]: %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_ack_timeout();
        int s;
        do_reset();
        tx_ack_en = 1'b0;
        wr(0, 8'h5A);
        wr(0, 8'h3C);
        wait_obs(1, 10, "ack_first");
        s = (obs_cyc.size() > 0) ? obs_cyc[0] : cyc;
        while (cyc < s + ACK_TIMEOUT - 1) tick(1);
        checks++;
        if (bus.ack_err !== 1'b0) begin
            errors++;
            $display("FAIL ack_early: ack_err %b at start+%0d, required 0", bus.ack_err, ACK_TIMEOUT - 1);
        end
        tick(1);
        checks++;
        if (bus.ack_err !== 1'b1) begin
            errors++;
            $display("FAIL ack_set: ack_err %b at start+%0d, required 1", bus.ack_err, ACK_TIMEOUT);
        end
        wait_obs(2, 10, "ack_second");
        checks++;
        if (obs_q.size() >= 2 && (obs_q[0] !== 8'h5A || obs_q[1] !== 8'h3C || obs_cyc[1] - s != ACK_TIMEOUT + 1)) begin
            errors++;
            $display("FAIL ack_second: bytes %h %h gap %0d, required 5a 3c %0d", obs_q[0], obs_q[1], obs_cyc[1] - s, ACK_TIMEOUT + 1);
        end
        tick(ACK_TIMEOUT + 10);
        checks++;
        if (bus.ack_err !== 1'b1 || obs_q.size() != 2 || bus.sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_sticky: ack_err %b sends %0d sched_busy %b, required 1 2 0", bus.ack_err, obs_q.size(), bus.sched_busy);
        end
    endtask

    task automatic test_simul_write_pop();
        do_reset();
        tx_hold = 1'b1;
        wr(0, 8'h44);
        wr(0, 8'h77);
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h44) begin
            errors++;
            $display("FAIL simul_grant: tx_start %b tx_data %h, required 1 44", bus.tx_start, bus.tx_data);
        end
        wr(0, 8'h78);
        wr(0, 8'h79);
        checks++;
        if (bus.ch_full !== 2'b00) begin
            errors++;
            $display("FAIL simul_count3: ch_full %b, required 00", bus.ch_full);
        end
        wr(0, 8'h7A);
        checks++;
        if (bus.ch_full !== 2'b01 || bus.ovf !== 2'b00) begin
            errors++;
            $display("FAIL simul_count4: ch_full %b ovf %b, required 01 00", bus.ch_full, bus.ovf);
        end
        tx_hold = 1'b0;
        exp_q = '{8'h44, 8'h77, 8'h78, 8'h79, 8'h7A};
        wait_obs(exp_q.size(), 200, "simul");
        tick(10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL simul_count: %0d bytes, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL simul_order[%0d]: %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int d, n0, n1, s0, s1;
        bit v0, v1;
        logic [7:0] b0, b1;
        logic [1:0] exp_ovf, exp_full;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            tx_hold = 1'b1;
            d = $urandom_range(0, 1);
            wr(d, 8'hE0 + 8'(it));
            wait_obs(1, 10, "rand_dummy");
            exp_q.push_back(8'hE0 + 8'(it));
            m_last = d[0];
            n0 = $urandom_range(0, 6);
            n1 = $urandom_range(0, 6);
            s0 = 0;
            s1 = 0;
            while (s0 < n0 || s1 < n1) begin
                v0 = (s0 < n0) && ($urandom_range(0, 1) == 1);
                v1 = (s1 < n1) && ($urandom_range(0, 1) == 1);
                b0 = 8'($urandom);
                b1 = 8'($urandom);
                if (v0) begin
                    if (m0_q.size() < DEPTH) m0_q.push_back(b0);
                    s0++;
                end
                if (v1) begin
                    if (m1_q.size() < DEPTH) m1_q.push_back(b1);
                    s1++;
                end
                bus.in0_valid = v0; bus.in0_data = b0;
                bus.in1_valid = v1; bus.in1_data = b1;
                tick(1);
                bus.in0_valid = 1'b0;
                bus.in1_valid = 1'b0;
            end
            exp_ovf  = {n1 > DEPTH, n0 > DEPTH};
            exp_full = {n1 >= DEPTH, n0 >= DEPTH};
            checks++;
            if (bus.ovf !== exp_ovf || bus.ch_full !== exp_full) begin
                errors++;
                $display("FAIL rand_flags[%0d]: ovf %b ch_full %b, required %b %b", it, bus.ovf, bus.ch_full, exp_ovf, exp_full);
            end
            tx_hold = 1'b0;
            model_drain();
            wait_obs(exp_q.size(), 300, "rand");
            tick(10);
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand_count[%0d]: %0d bytes, required %0d", it, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_order[%0d][%0d]: %h, required %h", it, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.in0_data  = 8'h00;
        bus.in1_data  = 8'h00;
        tick(3);
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_ack_timeout();
        test_simul_write_pop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
